// File: rtl/mem_cmd_split_arb.sv
// Round-robin arbiter over NUM_CH command channels; splits each command into MAX_BURST/BOUNDARY-safe sub-commands.
// First sub-command is registered one cycle after the input handshake; outputs hold while m_cmd_ready is low.
module mem_cmd_split_arb #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 4096,
  parameter int BOUNDARY  = 4096,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    s_cmd_valid,
  output logic [NUM_CH-1:0]    s_cmd_ready,
  input  logic [NUM_CH*64-1:0] s_cmd_address,
  input  logic [NUM_CH*32-1:0] s_cmd_length,
  output logic                 m_cmd_valid,
  input  logic                 m_cmd_ready,
  output logic [63:0]          m_cmd_address,
  output logic [31:0]          m_cmd_length,
  output logic [CH_W-1:0]      m_cmd_dest,
  output logic                 m_cmd_last,
  output logic [15:0]          drop_count
);
  localparam int OFF_W = $clog2(BOUNDARY);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_grant;
  logic [NUM_CH-1:0] r_s_ready;
  logic [63:0]       r_cur_addr;
  logic [31:0]       r_rem_len;
  logic              r_m_vld;
  logic [63:0]       r_m_addr;
  logic [31:0]       r_m_len;
  logic [CH_W-1:0]   r_m_dest;
  logic              r_m_last;
  logic [15:0]       r_drop;

  logic [63:0]       w_in_addr [NUM_CH];
  logic [31:0]       w_in_len  [NUM_CH];
  logic [CH_W-1:0]   w_grant;
  logic              w_grant_vld;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_rr_next;
  logic [63:0]       w_sel_addr;
  logic [31:0]       w_sel_len;
  logic [31:0]       w_first;
  logic [31:0]       w_next;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_arb_en;

  // Smallest of remaining length, burst cap and room to the next boundary, at 33 bits.
  function automatic logic [31:0] f_chunk(input logic [OFF_W-1:0] i_off, input logic [31:0] i_len);
    logic [32:0] w_room;
    logic [32:0] w_c;
    w_room = 33'(BOUNDARY) - 33'(i_off);
    w_c    = {1'b0, i_len};
    if (w_c > 33'(MAX_BURST)) w_c = 33'(MAX_BURST);
    if (w_c > w_room)         w_c = w_room;
    return 32'(w_c);
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_in_addr[g] = s_cmd_address[64*g +: 64];
    assign w_in_len[g]  = s_cmd_length[32*g +: 32];
  end

  // Scan from the highest offset down so the lowest offset from r_rr_ptr wins.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (s_cmd_valid[w_idx]) begin
        w_grant     = w_idx;
        w_grant_vld = 1'b1;
      end
    end
  end

  assign w_rr_next  = CH_W'((int'(r_grant) + 1) % NUM_CH);
  assign w_sel_addr = w_in_addr[r_grant];
  assign w_sel_len  = w_in_len[r_grant];
  assign w_first    = f_chunk(w_sel_addr[OFF_W-1:0], w_sel_len);
  assign w_next     = f_chunk(r_cur_addr[OFF_W-1:0], r_rem_len);
  assign w_in_hs    = (r_state == IDLE) && (|(r_s_ready & s_cmd_valid));
  assign w_out_hs   = r_m_vld && m_cmd_ready;
  assign w_arb_en   = ((r_state == IDLE) && (r_s_ready == '0)) ||
                      ((r_state == SPLIT) && w_out_hs && r_m_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_s_ready  <= '0;
      r_cur_addr <= '0;
      r_rem_len  <= '0;
      r_m_vld    <= 1'b0;
      r_m_addr   <= '0;
      r_m_len    <= '0;
      r_m_dest   <= '0;
      r_m_last   <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_s_ready <= '0;
      if (w_arb_en && w_grant_vld) begin
        r_s_ready <= NUM_CH'(1) << w_grant;
        r_grant   <= w_grant;
      end
      case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            r_rr_ptr <= w_rr_next;
            if (w_sel_len == '0) begin
              if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            end else begin
              r_state    <= SPLIT;
              r_m_vld    <= 1'b1;
              r_m_addr   <= w_sel_addr;
              r_m_len    <= w_first;
              r_m_dest   <= r_grant;
              r_m_last   <= (w_first == w_sel_len);
              r_cur_addr <= w_sel_addr + 64'(w_first);
              r_rem_len  <= w_sel_len - w_first;
            end
          end
        end
        SPLIT: begin
          if (w_out_hs) begin
            if (r_m_last) begin
              r_state <= IDLE;
              r_m_vld <= 1'b0;
            end else begin
              // r_cur_addr/r_rem_len already point past the sub-command being presented.
              r_m_addr   <= r_cur_addr;
              r_m_len    <= w_next;
              r_m_last   <= (w_next == r_rem_len);
              r_cur_addr <= r_cur_addr + 64'(w_next);
              r_rem_len  <= r_rem_len - w_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_cmd_ready   = r_s_ready;
  assign m_cmd_valid   = r_m_vld;
  assign m_cmd_address = r_m_addr;
  assign m_cmd_length  = r_m_len;
  assign m_cmd_dest    = r_m_dest;
  assign m_cmd_last    = r_m_last;
  assign drop_count    = r_drop;
endmodule

// File: tb/tb_mem_cmd_split_arb.sv
// Bench for mem_cmd_split_arb: per-channel command queues feed the DUT, a reference splitter and
// round-robin model fill a scoreboard, and a negedge monitor compares every presented sub-command.
`timescale 1ns/1ps
module tb_mem_cmd_split_arb;
  localparam int NUM_CH    = 4;
  localparam int MAX_BURST = 4096;
  localparam int BOUNDARY  = 4096;
  localparam int CH_W      = 2;

  typedef struct packed { logic [63:0] addr; logic [31:0] len; } cmd_t;
  typedef struct packed { logic [63:0] addr; logic [31:0] len; logic [CH_W-1:0] dest; logic last; } sub_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    s_cmd_valid;
  logic [NUM_CH-1:0]    s_cmd_ready;
  logic [NUM_CH*64-1:0] s_cmd_address;
  logic [NUM_CH*32-1:0] s_cmd_length;
  logic                 m_cmd_valid;
  logic                 m_cmd_ready;
  logic [63:0]          m_cmd_address;
  logic [31:0]          m_cmd_length;
  logic [CH_W-1:0]      m_cmd_dest;
  logic                 m_cmd_last;
  logic [15:0]          drop_count;

  mem_cmd_split_arb #(.NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST), .BOUNDARY(BOUNDARY)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .m_cmd_dest(m_cmd_dest), .m_cmd_last(m_cmd_last),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  cmd_t pend_q [NUM_CH][$];
  sub_t exp_q[$];
  int   grant_log[$];
  int   exp_rr;
  int   exp_drop;
  int   n_pop;
  int   rdy_mode;
  bit   chk_drop;
  time  acc_time;
  logic [NUM_CH-1:0] v_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference splitter: walk the command in plain 64-bit arithmetic.
  task automatic model_split(input int ch, input cmd_t c);
    longint unsigned a, rem, room, n;
    sub_t s;
    a   = c.addr;
    rem = c.len;
    if (rem == 0) begin
      exp_drop = (exp_drop < 65535) ? exp_drop + 1 : 65535;
      return;
    end
    while (rem > 0) begin
      room = BOUNDARY - (a % BOUNDARY);
      n = rem;
      if (n > MAX_BURST) n = MAX_BURST;
      if (n > room) n = room;
      s.addr = a;
      s.len  = 32'(n);
      s.dest = CH_W'(ch);
      s.last = (n == rem);
      exp_q.push_back(s);
      a   += n;
      rem -= n;
    end
  endtask

  task automatic apply();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (pend_q[ch].size() > 0) begin
        s_cmd_valid[ch]              = 1'b1;
        s_cmd_address[64*ch +: 64]   = pend_q[ch][0].addr;
        s_cmd_length[32*ch +: 32]    = pend_q[ch][0].len;
      end else begin
        s_cmd_valid[ch] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       m_cmd_ready = 1'b1;
      1:       m_cmd_ready = ($urandom_range(0, 3) != 0);
      default: m_cmd_ready = 1'b0;
    endcase
  endtask

  task automatic observe();
    int e;
    @(negedge clk);
    if (chk_drop) check("drop_count", 64'(drop_count), 64'(exp_drop));
    chk_drop = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (s_cmd_valid[ch] && s_cmd_ready[ch]) begin
        e = -1;
        for (int k = NUM_CH - 1; k >= 0; k--)
          if (v_prev[(exp_rr + k) % NUM_CH]) e = (exp_rr + k) % NUM_CH;
        check("grant", 64'(ch), 64'(e));
        grant_log.push_back(ch);
        model_split(ch, pend_q[ch].pop_front());
        exp_rr   = (ch + 1) % NUM_CH;
        chk_drop = 1'b1;
        acc_time = $time;
      end
    end
    v_prev = s_cmd_valid;
  endtask

  task automatic tick();
    observe();
    @(posedge clk);
    #1;
    apply();
  endtask

  function automatic int pending_total();
    int t = 0;
    for (int ch = 0; ch < NUM_CH; ch++) t += pend_q[ch].size();
    return t;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int cyc = 0;
    while ((pending_total() > 0 || exp_q.size() > 0 || m_cmd_valid || s_cmd_ready != '0) && cyc < budget) begin
      tick();
      cyc++;
    end
    check({"drain_", name}, 64'(cyc < budget), 64'(1));
    tick();
    tick();
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int cyc = 0;
    while (n_pop < target && cyc < budget) begin
      tick();
      cyc++;
    end
    check({"pop_wait_", name}, 64'(n_pop >= target), 64'(1));
  endtask

  task automatic push_cmd(input int ch, input logic [63:0] a, input logic [31:0] l);
    cmd_t c;
    c.addr = a;
    c.len  = l;
    pend_q[ch].push_back(c);
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the model's queue.
  sub_t held;
  sub_t exp_s;
  bit   stall = 1'b0;
  bit   prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall    = 1'b0;
      prev_vld = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 64'(m_cmd_valid), 64'(1));
        check("hold_addr", m_cmd_address, held.addr);
        check("hold_len_dest_last", 64'({m_cmd_length, m_cmd_dest, m_cmd_last}),
              64'({held.len, held.dest, held.last}));
      end
      if (m_cmd_valid && !prev_vld)
        check("first_latency", 64'($time - acc_time), 64'(10));
      if (m_cmd_valid && exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_sub: got addr 0x%0h len %0d, required no sub-command", m_cmd_address, m_cmd_length);
      end else if (m_cmd_valid && m_cmd_ready) begin
        exp_s = exp_q.pop_front();
        check("sub_addr", m_cmd_address, exp_s.addr);
        check("sub_len", 64'(m_cmd_length), 64'(exp_s.len));
        check("sub_dest", 64'(m_cmd_dest), 64'(exp_s.dest));
        check("sub_last", 64'(m_cmd_last), 64'(exp_s.last));
        n_pop++;
      end
      stall    = m_cmd_valid && !m_cmd_ready;
      prev_vld = m_cmd_valid;
      held     = {m_cmd_address, m_cmd_length, m_cmd_dest, m_cmd_last};
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int p0;
    int r;
    logic [31:0] l;
    rst = 1'b1;
    s_cmd_valid = '0;
    s_cmd_address = '0;
    s_cmd_length = '0;
    m_cmd_ready = 1'b0;
    rdy_mode = 0;
    exp_rr = 0;
    exp_drop = 0;
    n_pop = 0;
    chk_drop = 1'b0;
    v_prev = '0;
    acc_time = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_cmd_valid), 64'(0));
    check("rst_m_addr", m_cmd_address, 64'(0));
    check("rst_m_len", 64'(m_cmd_length), 64'(0));
    check("rst_s_ready", 64'(s_cmd_ready), 64'(0));
    check("rst_drop", 64'(drop_count), 64'(0));
    rst = 1'b0;
    apply();

    // Fairness: two short commands queued on every channel at once.
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < NUM_CH; ch++) push_cmd(ch, 64'h10000 * (ch + 1) + 64'(k * 64), 32'd64);
    grant_log.delete();
    apply();
    wait_drain("fair", 200);
    check("fair_count", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check("fair_order", 64'(grant_log[i]), 64'(i % 4));

    push_cmd(0, 64'h1000, 32'd256);
    apply();
    wait_drain("single", 50);
    check("single_drop", 64'(drop_count), 64'(0));
    push_cmd(1, 64'h0F80, 32'd512);
    apply();
    wait_drain("cross", 50);
    push_cmd(2, 64'h2000, 32'd10000);
    apply();
    wait_drain("long", 50);

    // Backpressure after the first of three sub-commands.
    p0 = n_pop;
    push_cmd(2, 64'h2000, 32'd10000);
    apply();
    wait_pops("bp", p0 + 1, 50);
    rdy_mode = 2;
    apply();
    repeat (5) tick();
    rdy_mode = 0;
    apply();
    wait_drain("bp", 50);
    check("bp_pops", 64'(n_pop - p0), 64'(3));

    push_cmd(3, 64'h5000, 32'd0);
    apply();
    wait_drain("zero", 50);
    check("zero_drop", 64'(drop_count), 64'(1));

    // Random traffic with random downstream stalls.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, NUM_CH - 1);
        if (pend_q[r].size() < 3) begin
          case ($urandom_range(0, 9))
            0:       l = 32'd0;
            1, 2:    l = 32'($urandom_range(1, 64));
            default: l = 32'($urandom_range(1, 12000));
          endcase
          push_cmd(r, {28'h0, 4'($urandom_range(0, 15)), 32'($urandom)}, l);
        end
      end
      tick();
    end
    rdy_mode = 0;
    apply();
    wait_drain("random", 20000);
    check("random_drop", 64'(drop_count), 64'(exp_drop));

    // Reset in the middle of a three-way split.
    p0 = n_pop;
    push_cmd(1, 64'h2000, 32'd10000);
    apply();
    wait_pops("rst", p0 + 1, 50);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", 64'(m_cmd_valid), 64'(0));
    check("midrst_m_addr", m_cmd_address, 64'(0));
    check("midrst_m_len_dest_last", 64'({m_cmd_length, m_cmd_dest, m_cmd_last}), 64'(0));
    check("midrst_drop", 64'(drop_count), 64'(0));
    exp_q.delete();
    for (int ch = 0; ch < NUM_CH; ch++) pend_q[ch].delete();
    exp_rr = 0;
    exp_drop = 0;
    chk_drop = 1'b0;
    apply();
    repeat (2) tick();
    rst = 1'b0;
    p0 = n_pop;
    push_cmd(0, 64'h7000, 32'd300);
    apply();
    wait_drain("post_rst", 50);
    check("post_rst_pops", 64'(n_pop - p0), 64'(1));
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_cmd_split_arb.md
Name: mem_cmd_split_arb

Overview:
- Parametrised successor to the single-channel memory command handshake (valid/ready, 64-bit address, 32-bit length).
- Arbitrates NUM_CH command channels round-robin.
- Splits each accepted command into sub-commands that never exceed MAX_BURST bytes and never cross a BOUNDARY-aligned address.
- Tags each sub-command with its source channel and a last flag. Sits between the user/TLB command sources and the DMA or memory-controller command port.

Parameters:
- NUM_CH, 4, number of input command channels; range 1..16.
- MAX_BURST, 4096, maximum sub-command length in bytes; power of two, at least 64.
- BOUNDARY, 4096, address boundary sub-commands must not cross; power of two, at least MAX_BURST.
- CH_W, max(1,$clog2(NUM_CH)), derived localparam; width of the dest field.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_cmd_valid  in  NUM_CH  per-channel command valid.
- s_cmd_ready  out  NUM_CH  per-channel command ready.
- s_cmd_address  in  NUM_CH*64  per-channel byte address; channel i at [64i+63:64i].
- s_cmd_length  in  NUM_CH*32  per-channel byte length; channel i at [32i+31:32i].
- m_cmd_valid  out  1  sub-command valid.
- m_cmd_ready  in  1  downstream ready.
- m_cmd_address  out  64  sub-command address.
- m_cmd_length  out  32  sub-command length.
- m_cmd_dest  out  CH_W  source channel of the sub-command.
- m_cmd_last  out  1  final sub-command of the original command.
- drop_count  out  16  count of zero-length commands dropped; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, rr_ptr=0. Reset asserts asynchronously, releases synchronously to clk.
- Reset mid-operation: the partially split command is discarded. No further sub-commands for it. drop_count is cleared.
- FSM states: IDLE, SPLIT.
- IDLE: grant is the first channel with s_cmd_valid=1, searching from rr_ptr upward modulo NUM_CH.
  - s_cmd_ready is a registered one-hot pulse for the granted channel, asserted for exactly one cycle.
  - Handshake is valid&&ready. The address and length are latched into cur_addr and rem_len; dest=grant; rr_ptr is set to grant+1 (mod NUM_CH).
  - A channel is never granted again until its current command has fully left.
  - If no channel is valid, stay in IDLE.
- Zero-length command: accepted in the normal way, produces no m_cmd output, increments drop_count (saturating), returns to IDLE. rr_ptr still advances.
- SPLIT: chunk = min(rem_len, MAX_BURST, BOUNDARY - (cur_addr mod BOUNDARY)), computed at 33-bit width to avoid overflow.
  - m_cmd_* is registered: the first sub-command is valid on the cycle after the input handshake.
  - On m_cmd_valid&&m_cmd_ready: cur_addr += chunk and rem_len -= chunk. The next sub-command is presented on the following cycle, so throughput is 1 sub-command per 2 cycles or better; back-to-back is allowed if registered ahead.
  - m_cmd_last=1 exactly when chunk == rem_len.
  - After the last handshake: return to IDLE. A new grant is allowed in the same cycle as the last handshake, with s_cmd_ready in the next cycle.
- Output stability: while m_cmd_valid=1 and m_cmd_ready=0, every m_cmd_* field holds stable. m_cmd_valid never deasserts without a handshake, except on reset.
- Address arithmetic: 64-bit, wraps modulo 2^64 silently. A length that would wrap the address is the caller's error; no check is made.
- Only one command is in flight; there is no input buffering. Channels not granted see s_cmd_ready=0.
- NUM_CH=1: the arbiter degenerates and m_cmd_dest is always 0.

Test Plan:
- Single command, ch0, addr 0x1000, len 256, m_cmd_ready=1 -> one sub-command: 0x1000/256, dest 0, last=1, one cycle after the handshake. drop_count=0.
- Boundary cross, ch1, addr 0x0F80, len 512 (MAX_BURST=BOUNDARY=4096) -> two sub-commands: 0x0F80/128 (last=0), then 0x1000/384 (last=1), both dest=1.
- Long command, ch2, addr 0x2000, len 10000 -> three sub-commands: 0x2000/4096, 0x3000/4096, 0x4000/1808; last set only on the third.
- Fairness: all 4 channels valid continuously, each with len 64 -> grants follow the order 0,1,2,3,0,1; no channel granted twice before all others are served.
- Backpressure plus zero-length: hold m_cmd_ready=0 for 5 cycles mid-split -> fields stable, no sub-command lost. Then issue a len 0 command on ch3 -> no m_cmd_valid, drop_count=1.
- Reset mid-split: assert rst after the first of three sub-commands -> all outputs 0 immediately (asynchronously). After release, a new ch0 command is served with no leftover sub-commands.
